// File: rtl/hamming_decode_arbiter.sv
// Round-robin shared Hamming(7,4) SEC decoder with a registered result stage.
// Latency: 1 clock from accept (req_valid & req_ready) to out_valid.
// Backpressure: grants only when the output stage is empty or being drained
// (out_ready); a held result stalls every requester.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   per-requester handshake, req_ready is one-hot
//   req_code          7 bits per requester, slot i = code[7:1] of requester i
//   req_parity        per-requester parity type (0 even, 1 odd)
//   out_valid/ready   result handshake
//   out_data/error/src corrected nibble, corrected-error flag, source index
//   clr_count         synchronous clear of err_count
//   err_count         saturating count of loaded results with error=1
module hamming_decode_arbiter #(
  parameter int NREQ  = 4,
  parameter int SRC_W = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [7*NREQ-1:0] req_code,
  input  logic [NREQ-1:0]   req_parity,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_data,
  output logic              out_error,
  output logic [SRC_W-1:0]  out_src,
  input  logic              clr_count,
  output logic [CNT_W-1:0]  err_count
);

  logic             r_out_valid;
  logic [3:0]       r_out_data;
  logic             r_out_error;
  logic [SRC_W-1:0] r_out_src;
  logic [SRC_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_err_count;

  logic             w_load_en;
  logic [NREQ-1:0]  w_grant;
  logic             w_found;
  logic [SRC_W-1:0] w_gnt_idx;
  logic [SRC_W:0]   w_cand;
  logic [SRC_W-1:0] w_ptr_nxt;
  logic [6:0]       w_code;
  logic             w_par;
  logic [2:0]       w_syn;
  logic [6:0]       w_fixed;
  logic [3:0]       w_data;
  logic             w_error;

  assign w_load_en = !r_out_valid || out_ready;

  // Search from the pointer upward with wrap; the first valid requester wins.
  always_comb begin
    w_grant   = '0;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = {1'b0, r_ptr} + (SRC_W+1)'(k);
      if (w_cand >= (SRC_W+1)'(NREQ)) begin
        w_cand = w_cand - (SRC_W+1)'(NREQ);
      end
      if (w_load_en && !w_found && req_valid[w_cand[SRC_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand[SRC_W-1:0];
      end
    end
    if (w_found) begin
      w_grant[w_gnt_idx] = 1'b1;
    end
  end

  // No grant may escape while reset is asserted (state is already cleared,
  // so load_en alone would otherwise let a grant through).
  assign req_ready = w_grant & {NREQ{rst_n}};

  assign w_ptr_nxt = (w_gnt_idx == SRC_W'(NREQ-1)) ? '0 : w_gnt_idx + SRC_W'(1);

  always_comb begin
    w_code = '0;
    w_par  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_code = req_code[7*i +: 7];
        w_par  = req_parity[i];
      end
    end
  end

  // w_code[n-1] holds code bit c<n>. Odd parity folds p into every check.
  assign w_syn[0] = w_code[0] ^ w_code[2] ^ w_code[4] ^ w_code[6] ^ w_par;
  assign w_syn[1] = w_code[1] ^ w_code[2] ^ w_code[5] ^ w_code[6] ^ w_par;
  assign w_syn[2] = w_code[3] ^ w_code[4] ^ w_code[5] ^ w_code[6] ^ w_par;

  // SEC only: a double error yields a nonzero syndrome and is miscorrected.
  always_comb begin
    w_fixed = w_code;
    w_error = 1'b0;
    if (w_syn != 3'd0) begin
      w_fixed[w_syn - 3'd1] = ~w_code[w_syn - 3'd1];
      w_error               = 1'b1;
    end
    w_data = {w_fixed[6], w_fixed[5], w_fixed[4], w_fixed[2]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_error <= 1'b0;
      r_out_src   <= '0;
      r_ptr       <= '0;
    end else if (w_found) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_error <= w_error;
      r_out_src   <= w_gnt_idx;
      r_ptr       <= w_ptr_nxt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Counted at load time; clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (clr_count) begin
      r_err_count <= '0;
    end else if (w_found && w_error && (r_err_count != {CNT_W{1'b1}})) begin
      r_err_count <= r_err_count + CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_error = r_out_error;
  assign out_src   = r_out_src;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_hamming_decode_arbiter.sv
// Directed bench for hamming_decode_arbiter: decode vector table plus
// round-robin, backpressure, saturation and mid-stream reset sequences.
// A second instance with a 2-bit counter shares all inputs for saturation.
module tb_hamming_decode_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [27:0] req_code;
  logic [3:0]  req_parity;
  logic [3:0]  req_ready;
  logic [3:0]  req_ready2;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [3:0]  out_data, out_data2;
  logic        out_error, out_error2;
  logic [1:0]  out_src, out_src2;
  logic        clr_count;
  logic [15:0] err_count;
  logic [1:0]  err_count2;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  hamming_decode_arbiter #(.NREQ(4), .SRC_W(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_code(req_code),
    .req_parity(req_parity), .req_ready(req_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_error(out_error),
    .out_src(out_src), .clr_count(clr_count), .err_count(err_count)
  );

  hamming_decode_arbiter #(.NREQ(4), .SRC_W(2), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_code(req_code),
    .req_parity(req_parity), .req_ready(req_ready2), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_error(out_error2),
    .out_src(out_src2), .clr_count(clr_count), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         src;
    logic [6:0] code;
    logic       par;
    logic [3:0] data;
    logic       err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [6:0] c, input logic p);
    req_code[7*i +: 7] = c;
    req_parity[i]      = p;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = '0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    vecs[0] = '{0, 7'b1010101, 1'b0, 4'b1011, 1'b0};
    vecs[1] = '{2, 7'b1000101, 1'b0, 4'b1011, 1'b1};
    vecs[2] = '{1, 7'b1011110, 1'b1, 4'b1011, 1'b0};
    vecs[3] = '{3, 7'b0000000, 1'b0, 4'b0000, 1'b0};
    vecs[4] = '{0, 7'b0000001, 1'b0, 4'b0000, 1'b1};
    vecs[5] = '{2, 7'b0000000, 1'b1, 4'b1000, 1'b1};
    vecs[6] = '{1, 7'b1111111, 1'b0, 4'b1111, 1'b0};
    vecs[7] = '{3, 7'b0111111, 1'b0, 4'b1111, 1'b1};
    vecs[8] = '{0, 7'b1010110, 1'b0, 4'b1010, 1'b1};  // double error, miscorrected
    vecs[9] = '{1, 7'b0010011, 1'b0, 4'b0110, 1'b1};

    rst_n      = 1'b0;
    req_valid  = 4'hF;
    req_code   = '0;
    req_parity = '0;
    out_ready  = 1'b1;
    clr_count  = 1'b0;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_out_src",   32'(out_src),   32'h0);
    chk("rst_err_count", 32'(err_count), 32'h0);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst_n = 1'b1;
    tick();

    // Decode table, one single-requester transfer per entry.
    for (int v = 0; v < 10; v++) begin
      req_valid = '0;
      set_req(vecs[v].src, vecs[v].code, vecs[v].par);
      req_valid[vecs[v].src] = 1'b1;
      #1;
      chk("tbl_ready", 32'(req_ready), 32'(1 << vecs[v].src));
      tick();
      if (vecs[v].err) exp_cnt++;
      chk("tbl_valid", 32'(out_valid), 32'h1);
      chk("tbl_data",  32'(out_data),  32'(vecs[v].data));
      chk("tbl_error", 32'(out_error), 32'(vecs[v].err));
      chk("tbl_src",   32'(out_src),   32'(vecs[v].src));
      chk("tbl_count", 32'(err_count), 32'(exp_cnt));
      req_valid = '0;
    end

    // Round robin with all four requesters continuously valid.
    pulse_reset();
    for (int i = 0; i < 4; i++) set_req(i, 7'b1010101, 1'b0);
    req_valid = 4'hF;
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      #1;
      chk("rr_ready", 32'(req_ready), 32'(1 << (n % 4)));
      tick();
      chk("rr_valid", 32'(out_valid), 32'h1);
      chk("rr_src",   32'(out_src),   32'(n % 4));
    end

    // Backpressure: req1 and req3 pending while the output stalls.
    req_valid = '0;
    tick();
    chk("bp_drain", 32'(out_valid), 32'h0);
    set_req(1, 7'b0110011, 1'b0);
    set_req(3, 7'b1111111, 1'b0);
    req_valid = 4'b1010;
    out_ready = 1'b0;
    #1;
    chk("bp_first_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid[1] = 1'b0;
    chk("bp_first_src",  32'(out_src),  32'h1);
    chk("bp_first_data", 32'(out_data), 32'h6);
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("bp_hold_ready", 32'(req_ready), 32'h0);
      tick();
      chk("bp_hold_valid", 32'(out_valid), 32'h1);
      chk("bp_hold_src",   32'(out_src),   32'h1);
      chk("bp_hold_data",  32'(out_data),  32'h6);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_second_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    chk("bp_second_valid", 32'(out_valid), 32'h1);
    chk("bp_second_src",   32'(out_src),   32'h3);
    chk("bp_second_data",  32'(out_data),  32'hF);
    tick();
    chk("bp_empty_valid", 32'(out_valid), 32'h0);
    chk("bp_hold_src_after", 32'(out_src), 32'h3);

    // Saturation on the 2-bit counter, then clear against an error grant.
    pulse_reset();
    set_req(0, 7'b1000101, 1'b0);
    req_valid = 4'b0001;
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk("sat_cnt2",  32'(err_count2), 32'((n > 3) ? 3 : n));
      chk("sat_cnt16", 32'(err_count),  32'(n));
    end
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    chk("clr_cnt2",  32'(err_count2), 32'h0);
    chk("clr_cnt16", 32'(err_count),  32'h0);

    // Mid-stream reset with a result held.
    req_valid = '0;
    tick();
    for (int i = 0; i < 4; i++) set_req(i, 7'b1000101, 1'b0);
    req_valid = 4'hF;
    out_ready = 1'b0;
    tick();
    chk("mr_pre_src",   32'(out_src),   32'h1);
    chk("mr_pre_count", 32'(err_count), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(out_valid),  32'h0);
    chk("mr_count", 32'(err_count),  32'h0);
    chk("mr_cnt2",  32'(err_count2), 32'h0);
    chk("mr_ready", 32'(req_ready),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mr_post_ready", 32'(req_ready), 32'h1);
    tick();
    chk("mr_post_valid", 32'(out_valid), 32'h1);
    chk("mr_post_src",   32'(out_src),   32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
